menu_navegador_param: RTL and testbench
=======================================

Name: menu_navegador_param

Overview:
Parametrised successor to the editor's menu controller. It walks a grid of N_FILAS rows, where each row has its own column count. The grid wraps or clamps at its edges, selected by parameter.
On "elige" it applies the editor setting under the cursor (case, colour, scale) or fires a one-cycle command pulse (nuevo/guardar/cerrar).
Sits between the debounced push-button block and the text renderer / file-control logic. Everything is clocked on clk; there are no button-derived clocks.

Parameters:
N_FILAS, 6, number of menu rows (1..7).
POS_W, 3, width of where_fila / where_columna.
COLS_POR_FILA, {3'd3,3'd6,3'd2,3'd1,3'd1,3'd1}, packed column count per row; row N_FILAS is in the MSBs, row 1 in the LSBs.
WRAP, 0, 0 = clamp at edges; 1 = wrap around.
REPEAT_DELAY, 50_000_000, hold cycles before the first auto-repeat (feature only).
REPEAT_RATE, 10_000_000, cycles between repeats (feature only).

Ports:
clk  in  1  system clock (100 MHz).
reset  in  1  asynchronous, active-high reset.
boton_arriba  in  1  debounced level, synchronous to clk.
boton_abajo  in  1  debounced level.
boton_izq  in  1  debounced level.
boton_der  in  1  debounced level.
boton_elige  in  1  debounced level.
where_fila  out  POS_W  cursor row, 1-based.
where_columna  out  POS_W  cursor column, 1-based.
text_red  out  1  text colour bit.
text_green  out  1  text colour bit.
text_blue  out  1  text colour bit.
char_scale  out  10  character scale.
es_mayuscula  out  1  1 = uppercase.
nuevo  out  1  one-cycle command pulse.
guardar  out  1  one-cycle command pulse.
cerrar  out  1  one-cycle command pulse.
sel_valid  out  1  one-cycle pulse on every elige.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (all outputs registered):
  - where_fila=1, where_columna=1.
  - char_scale=2.
  - {red,green,blue}=3'b001.
  - es_mayuscula=1.
  - nuevo, guardar, cerrar, sel_valid = 0.
  - FSM enters WAIT_REL, so a button held through reset is ignored. Counters are cleared.
- FSM states: IDLE, EXEC, WAIT_REL.
- IDLE:
  - If any button is high, latch one command by priority arriba > abajo > izq > der > elige, then go to EXEC.
  - Simultaneous presses: only the highest-priority button is acted on.
- EXEC: lasts exactly one cycle. All output updates and pulses are registered on the edge leaving EXEC. Latency is 2 cycles from the first sampled high input to the visible output. Next state is WAIT_REL.
- WAIT_REL: stay until all five inputs are low, then go to IDLE. One action per press.
- Navigation:
  - Let C = COLS_POR_FILA of the current row.
  - der: fila+1; at N_FILAS it holds (WRAP=0) or goes to 1 (WRAP=1). where_columna is set to 1.
  - izq: fila-1; at 1 it holds or goes to N_FILAS. where_columna is set to 1.
  - abajo: col+1; at C it holds or goes to 1.
  - arriba: col-1; at 1 it holds or goes to C.
  - A row with C=1 never changes column.
- Elige action (sel_valid pulses for every elige):
  - Row 1: nuevo pulse. Row 2: guardar pulse. Row 3: cerrar pulse.
  - Row 4: es_mayuscula = (col==1).
  - Row 5: col 1..6 sets RGB to 001, 010, 100, 011, 101, 110 respectively.
  - Row 6: char_scale = col, zero-extended to 10 bits.
  - Rows > 6: sel_valid only.
- Reset asserted mid-EXEC: no pulse is emitted; all outputs take their reset values immediately.
- Arithmetic is done at POS_W width. Positions never leave the range 1..limit.

Optional Feature:
Macro MENU_AUTOREPEAT_EN.
- Defined:
  - In WAIT_REL, a still-held navigation button (the same one that was latched) is counted.
  - After REPEAT_DELAY cycles the FSM re-enters EXEC.
  - After that, it re-enters EXEC every REPEAT_RATE cycles while the button stays held.
  - Elige never repeats. Releasing the button clears the counter.
- Undefined: one action per press. The counter logic and the REPEAT_* parameters are unused and must synthesise away.

Decomposition:
- Package menu_pkg holds:
  - FSM state enum.
  - Command enum: NONE, UP, DOWN, LEFT, RIGHT, SEL.
  - Colour code constants.
  - Default COLS_POR_FILA.
  - Row-index constants FILA_NUEVO..FILA_ESCALA.
- Sub-module menu_repeat_timer (counter with delay/rate compare, load and clear). It is instantiated only under MENU_AUTOREPEAT_EN.

Test Plan:
1. Reset, then der×7 (each press 3 cycles high, 3 low) -> fila steps 2..6 and holds at 6. Each step updates 2 cycles after the rise. Column stays 1.
2. fila=5, abajo×7 (WRAP=0) -> columna reaches 6 and holds. Re-run with WRAP=1 -> columna goes 6→1 on the 6th press.
3. fila=5, col=4, elige -> RGB=011 and sel_valid high exactly 1 cycle. Then fila=6, col=3, elige -> char_scale=3.
4. fila=2, elige held 100 cycles -> guardar high exactly 1 cycle. Arriba+der pressed together -> only the column decrements.
5. Button held through reset deassertion -> no action until released and pressed again. Reset pulse during EXEC of fila=1 elige -> nuevo stays 0.
6. MENU_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5, abajo held 40 cycles at fila=5 -> steps at hold cycles 0, 20, 25, 30, 35, clamped at col 6.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared types and constants for the parametrised menu navigator.
package menu_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_REL} state_t;
  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT, SEL} cmd_t;

  localparam logic [2:0] RGB_AZUL     = 3'b001;
  localparam logic [2:0] RGB_VERDE    = 3'b010;
  localparam logic [2:0] RGB_ROJO     = 3'b100;
  localparam logic [2:0] RGB_CIAN     = 3'b011;
  localparam logic [2:0] RGB_MAGENTA  = 3'b101;
  localparam logic [2:0] RGB_AMARILLO = 3'b110;

  // Row N in the MSBs, row 1 in the LSBs
  localparam logic [17:0] COLS_DEF = {3'd3, 3'd6, 3'd2, 3'd1, 3'd1, 3'd1};

  localparam int FILA_NUEVO   = 1;
  localparam int FILA_GUARDAR = 2;
  localparam int FILA_CERRAR  = 3;
  localparam int FILA_MAYUS   = 4;
  localparam int FILA_COLOR   = 5;
  localparam int FILA_ESCALA  = 6;

  function automatic logic [2:0] rgb_of(input int col, input logic [2:0] cur);
    case (col)
      1:       rgb_of = RGB_AZUL;
      2:       rgb_of = RGB_VERDE;
      3:       rgb_of = RGB_ROJO;
      4:       rgb_of = RGB_CIAN;
      5:       rgb_of = RGB_MAGENTA;
      6:       rgb_of = RGB_AMARILLO;
      default: rgb_of = cur;
    endcase
  endfunction

endpackage

// File: rtl/menu_repeat_timer.sv
// Hold counter for auto-repeat: fires after DELAY held cycles, then every RATE.
module menu_repeat_timer #(
  parameter int DELAY = 50_000_000,
  parameter int RATE  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic fire
);
  localparam int MAXV  = (DELAY > RATE) ? DELAY : RATE;
  localparam int CNT_W = $clog2(MAXV + 1);

  logic [CNT_W-1:0] cnt, target;
  logic             first;

  assign target = first ? CNT_W'(DELAY - 1) : CNT_W'(RATE - 1);
  assign fire   = hold && (cnt == target);

  // Releasing the button clears both the count and the first-delay phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      first <= 1'b1;
    end else if (!hold) begin
      cnt   <= '0;
      first <= 1'b1;
    end else if (fire) begin
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/menu_navegador_param.sv
// Grid menu controller: cursor navigation, setting apply and command pulses.
// Optional auto-repeat of held navigation buttons with MENU_AUTOREPEAT_EN.
module menu_navegador_param
  import menu_pkg::*;
#(
  parameter int                        N_FILAS       = 6,
  parameter int                        POS_W         = 3,
  parameter logic [N_FILAS*POS_W-1:0]  COLS_POR_FILA = COLS_DEF,
  parameter bit                        WRAP          = 1'b0,
  parameter int                        REPEAT_DELAY  = 50_000_000,
  parameter int                        REPEAT_RATE   = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             boton_arriba,
  input  logic             boton_abajo,
  input  logic             boton_izq,
  input  logic             boton_der,
  input  logic             boton_elige,
  output logic [POS_W-1:0] where_fila,
  output logic [POS_W-1:0] where_columna,
  output logic             text_red,
  output logic             text_green,
  output logic             text_blue,
  output logic [9:0]       char_scale,
  output logic             es_mayuscula,
  output logic             nuevo,
  output logic             guardar,
  output logic             cerrar,
  output logic             sel_valid,
  output logic             busy
);
  localparam logic [POS_W-1:0] ONE       = POS_W'(1);
  localparam logic [POS_W-1:0] LAST_FILA = POS_W'(N_FILAS);

  state_t           state, state_nx;
  cmd_t             cmd_q, cmd_pri;
  logic             any_btn, rep_fire;
  logic [POS_W-1:0] fila, col, cur_cols, fila_nx, col_nx;
  logic [2:0]       rgb;

  assign any_btn = boton_arriba | boton_abajo | boton_izq | boton_der | boton_elige;

  always_comb begin
    cmd_pri = NONE;
    if      (boton_arriba) cmd_pri = UP;
    else if (boton_abajo)  cmd_pri = DOWN;
    else if (boton_izq)    cmd_pri = LEFT;
    else if (boton_der)    cmd_pri = RIGHT;
    else if (boton_elige)  cmd_pri = SEL;
  end

  always_comb begin
    cur_cols = ONE;
    for (int i = 0; i < N_FILAS; i++)
      if (fila == POS_W'(i + 1)) cur_cols = COLS_POR_FILA[i*POS_W +: POS_W];
  end

`ifdef MENU_AUTOREPEAT_EN
  logic held;
  always_comb begin
    held = 1'b0;
    case (cmd_q)
      UP:      held = boton_arriba;
      DOWN:    held = boton_abajo;
      LEFT:    held = boton_izq;
      RIGHT:   held = boton_der;
      default: held = 1'b0;
    endcase
  end

  menu_repeat_timer #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rep (
    .clk   (clk),
    .reset (reset),
    .hold  (held && (state != IDLE)),
    .fire  (rep_fire)
  );
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_REL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (any_btn) state_nx = EXEC;
      EXEC:     state_nx = WAIT_REL;
      WAIT_REL: if (rep_fire)     state_nx = EXEC;
                else if (!any_btn) state_nx = IDLE;
      default:  state_nx = WAIT_REL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cmd_q <= NONE;
    else if (state == IDLE && any_btn)  cmd_q <= cmd_pri;
  end

  always_comb begin
    fila_nx = fila;
    col_nx  = col;
    case (cmd_q)
      UP:    if (col > ONE)           col_nx = col - ONE;
             else if (WRAP)           col_nx = cur_cols;
      DOWN:  if (col < cur_cols)      col_nx = col + ONE;
             else if (WRAP)           col_nx = ONE;
      LEFT:  begin
               col_nx = ONE;
               if (fila > ONE)        fila_nx = fila - ONE;
               else if (WRAP)         fila_nx = LAST_FILA;
             end
      RIGHT: begin
               col_nx = ONE;
               if (fila < LAST_FILA)  fila_nx = fila + ONE;
               else if (WRAP)         fila_nx = ONE;
             end
      default: ;
    endcase
  end

  // All visible effects land on the edge that leaves EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fila         <= ONE;
      col          <= ONE;
      rgb          <= RGB_AZUL;
      char_scale   <= 10'd2;
      es_mayuscula <= 1'b1;
      nuevo        <= 1'b0;
      guardar      <= 1'b0;
      cerrar       <= 1'b0;
      sel_valid    <= 1'b0;
    end else begin
      nuevo     <= 1'b0;
      guardar   <= 1'b0;
      cerrar    <= 1'b0;
      sel_valid <= 1'b0;
      if (state == EXEC) begin
        fila <= fila_nx;
        col  <= col_nx;
        if (cmd_q == SEL) begin
          sel_valid <= 1'b1;
          case (int'(fila))
            FILA_NUEVO:   nuevo        <= 1'b1;
            FILA_GUARDAR: guardar      <= 1'b1;
            FILA_CERRAR:  cerrar       <= 1'b1;
            FILA_MAYUS:   es_mayuscula <= (col == ONE);
            FILA_COLOR:   rgb          <= rgb_of(int'(col), rgb);
            FILA_ESCALA:  char_scale   <= 10'(col);
            default: ;
          endcase
        end
      end
    end
  end

  assign where_fila    = fila;
  assign where_columna = col;
  assign {text_red, text_green, text_blue} = rgb;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_menu_navegador_param.sv
// Directed bench for menu_navegador_param: clamp (u0) and wrap (u1) instances share stimulus.
module tb_menu_navegador_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arriba = 0, abajo = 0, izq = 0, der = 0, elige = 0;

  logic [2:0] fila0, col0, fila1, col1;
  logic       r0, g0, b0, r1, g1, b1;
  logic [9:0] scale0, scale1;
  logic       may0, nue0, gua0, cer0, sv0, busy0;
  logic       may1, nue1, gua1, cer1, sv1, busy1;

  int checks = 0, errors = 0;
  int n_sel = 0, n_nuevo = 0, n_guardar = 0, n_cerrar = 0;

  always #5 clk = ~clk;

  menu_navegador_param #(.WRAP(1'b0), .REPEAT_DELAY(20), .REPEAT_RATE(5)) u0 (
    .clk(clk), .reset(reset),
    .boton_arriba(arriba), .boton_abajo(abajo), .boton_izq(izq), .boton_der(der), .boton_elige(elige),
    .where_fila(fila0), .where_columna(col0),
    .text_red(r0), .text_green(g0), .text_blue(b0), .char_scale(scale0), .es_mayuscula(may0),
    .nuevo(nue0), .guardar(gua0), .cerrar(cer0), .sel_valid(sv0), .busy(busy0));

  menu_navegador_param #(.WRAP(1'b1), .REPEAT_DELAY(20), .REPEAT_RATE(5)) u1 (
    .clk(clk), .reset(reset),
    .boton_arriba(arriba), .boton_abajo(abajo), .boton_izq(izq), .boton_der(der), .boton_elige(elige),
    .where_fila(fila1), .where_columna(col1),
    .text_red(r1), .text_green(g1), .text_blue(b1), .char_scale(scale1), .es_mayuscula(may1),
    .nuevo(nue1), .guardar(gua1), .cerrar(cer1), .sel_valid(sv1), .busy(busy1));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // {elige, der, izq, abajo, arriba}
  task automatic set_btn(input logic [4:0] m);
    {elige, der, izq, abajo, arriba} = m;
  endtask

  task automatic sample();
    @(posedge clk); #1;
    n_sel     += int'(sv0);
    n_nuevo   += int'(nue0);
    n_guardar += int'(gua0);
    n_cerrar  += int'(cer0);
  endtask

  task automatic press(input logic [4:0] m, input int hi = 3, input int lo = 3);
    @(negedge clk); set_btn(m);
    repeat (hi) sample();
    @(negedge clk); set_btn(5'b0);
    repeat (lo) sample();
  endtask

  task automatic clr_cnt();
    n_sel = 0; n_nuevo = 0; n_guardar = 0; n_cerrar = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; set_btn(5'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (2) sample();
    clr_cnt();
  endtask

  localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_L = 5'b00100,
                         B_R = 5'b01000, B_SEL = 5'b10000;

  initial begin
    // Reset values
    repeat (2) @(posedge clk); #1;
    chk("rst_fila", fila0, 1);
    chk("rst_col", col0, 1);
    chk("rst_scale", scale0, 2);
    chk("rst_rgb", {r0, g0, b0}, 3'b001);
    chk("rst_may", may0, 1);
    chk("rst_pulses", {nue0, gua0, cer0, sv0}, 0);
    chk("rst_busy", busy0, 1);
    @(negedge clk); reset = 1'b0;
    repeat (2) sample();
    chk("idle_busy", busy0, 0);

    // T1: der x7, exact 2-cycle latency on the first press
    @(negedge clk); der = 1'b1;
    @(posedge clk); #1; chk("lat_cyc1", fila0, 1);
    @(posedge clk); #1; chk("lat_cyc2", fila0, 2);
    @(posedge clk);
    @(negedge clk); der = 1'b0;
    repeat (3) sample();
    for (int k = 2; k <= 7; k++) begin
      press(B_R);
      chk($sformatf("der%0d_clamp", k), fila0, (k + 1 > 6) ? 6 : k + 1);
      chk($sformatf("der%0d_wrap", k), fila1, (k % 6) + 1);
    end
    chk("der_col", col0, 1);

    // T2: row 5, abajo x7
    do_reset();
    repeat (4) press(B_R);
    chk("f5_clamp", fila0, 5);
    chk("f5_wrap", fila1, 5);
    for (int k = 1; k <= 7; k++) begin
      press(B_DN);
      chk($sformatf("dn%0d_clamp", k), col0, (k + 1 > 6) ? 6 : k + 1);
      chk($sformatf("dn%0d_wrap", k), col1, (k == 6) ? 1 : (k == 7) ? 2 : k + 1);
    end

    // T3: colour and scale
    do_reset();
    repeat (4) press(B_R);
    repeat (3) press(B_DN);
    press(B_SEL);
    chk("rgb_col4", {r0, g0, b0}, 3'b011);
    chk("sel_once", n_sel, 1);
    press(B_R);
    chk("f6_col", col0, 1);
    chk("scale_pre", scale0, 2);
    repeat (2) press(B_DN);
    press(B_SEL);
    chk("scale_col3", scale0, 3);

    // T4: long elige on row 2, priority, case and edges
    do_reset();
    press(B_R);
    press(B_SEL, 100, 3);
    chk("guardar_once", n_guardar, 1);
    chk("guardar_sel", n_sel, 1);
    chk("guardar_other", n_nuevo + n_cerrar, 0);
    press(B_R); press(B_R);
    chk("f4", fila0, 4);
    press(B_DN);
    press(B_SEL);
    chk("may_col2", may0, 0);
    press(B_UP);
    press(B_SEL);
    chk("may_col1", may0, 1);
    press(B_R);
    repeat (2) press(B_DN);
    press(B_UP | B_R);
    chk("prio_col", col0, 2);
    chk("prio_fila", fila0, 5);
    do_reset();
    press(B_L);
    chk("izq_clamp", fila0, 1);
    chk("izq_wrap", fila1, 6);
    press(B_UP);
    chk("up_c1_wrap", col1, 3);
    do_reset();
    repeat (2) press(B_R);
    press(B_SEL);
    chk("cerrar_once", n_cerrar, 1);

    // T5: held through reset, then reset during EXEC
    @(negedge clk); reset = 1'b1; der = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (5) sample();
    chk("held_rst", fila0, 1);
    @(negedge clk); der = 1'b0;
    repeat (3) sample();
    chk("held_rel", fila0, 1);
    press(B_R);
    chk("held_repress", fila0, 2);
    do_reset();
    @(negedge clk); elige = 1'b1;
    @(posedge clk); #2; reset = 1'b1;
    sample();
    chk("midexec_nuevo", nue0, 0);
    @(negedge clk); reset = 1'b0;
    repeat (4) sample();
    @(negedge clk); elige = 1'b0;
    repeat (3) sample();
    chk("midexec_cnt", n_nuevo + n_sel, 0);
    press(B_SEL);
    chk("nuevo_once", n_nuevo, 1);

`ifdef MENU_AUTOREPEAT_EN
    // T6: auto-repeat at hold cycles 0, 20, 25, 30, 35
    do_reset();
    repeat (4) press(B_R);
    press(B_DN, 19, 3);
    chk("rep_before_delay", col0, 2);
    press(B_DN, 40, 3);
    chk("rep_col", col0, 6);
    press(B_SEL, 40, 3);
    chk("rep_sel_once", n_sel, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
